// File: rtl/lock_indicator_ctrl.sv
// lock_indicator_ctrl
// Indicator stage for the 24-bit sequence lock. It turns the checker's
// one-cycle pass/fail verdicts and the sticky lockout level into timed
// LED patterns (active-low) and an optional piezo square-wave tone.
//
// Build option: define LOCK_INDICATOR_BEEP_EN to build the tone generator.
// Without it, beep is tied low and the LED/busy behaviour is unchanged.
//
// All outputs are registered. They are loaded from the next-state
// decode, so a pulse sampled at an edge is visible right after that edge.

module lock_indicator_ctrl #(
    parameter int HOLD_CYCLES  = 25000000,
    parameter int BLINK_CYCLES = 12500000,
    parameter int TONE_HALF    = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pass_pulse,
    input  logic       fail_pulse,
    input  logic       lockout,
    output logic [1:0] led_r,
    output logic [1:0] led_g,
    output logic       beep,
    output logic       busy
);

    localparam logic [24:0] HOLD_MAX  = 25'(HOLD_CYCLES - 1);
    localparam logic [23:0] BLINK_MAX = 24'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PASS_SHOW,
        FAIL_SHOW,
        LOCKED
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [24:0] hold_cnt;
    logic [23:0] blink_cnt;
    logic        blink_off;
    logic        blink_off_nxt;
    logic        hold_restart;
    logic        red_on_nxt;

    // Next-state decode: lockout beats fail beats pass beats hold timeout
    always_comb begin
        state_nxt     = state;
        hold_restart  = 1'b0;
        blink_off_nxt = 1'b0;

        if (state == LOCKED || lockout) begin
            state_nxt = LOCKED;
        end else if (fail_pulse) begin
            state_nxt    = FAIL_SHOW;
            hold_restart = 1'b1;
        end else if (pass_pulse) begin
            state_nxt    = PASS_SHOW;
            hold_restart = 1'b1;
        end else if ((state == PASS_SHOW || state == FAIL_SHOW) && hold_cnt == HOLD_MAX) begin
            state_nxt = IDLE;
        end

        // The blink phase starts with red on at lock entry and flips on each wrap
        if (state_nxt == LOCKED && state == LOCKED) begin
            blink_off_nxt = (blink_cnt == BLINK_MAX) ? ~blink_off : blink_off;
        end

        red_on_nxt = (state_nxt == FAIL_SHOW) || (state_nxt == LOCKED && !blink_off_nxt);
    end

    // Main FSM: state, hold/blink timers and the registered LED/busy outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            blink_off <= 1'b0;
            led_r     <= 2'b11;
            led_g     <= 2'b11;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            blink_off <= blink_off_nxt;

            if (state_nxt != state || hold_restart ||
                !(state_nxt == PASS_SHOW || state_nxt == FAIL_SHOW)) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 25'd1;
            end

            if (state_nxt == LOCKED && state == LOCKED) begin
                blink_cnt <= (blink_cnt == BLINK_MAX) ? '0 : blink_cnt + 24'd1;
            end else begin
                blink_cnt <= '0;
            end

            led_r <= red_on_nxt ? 2'b00 : 2'b11;
            led_g <= (state_nxt == PASS_SHOW) ? 2'b00 : 2'b11;
            busy  <= (state_nxt != IDLE);
        end
    end

`ifdef LOCK_INDICATOR_BEEP_EN

    localparam logic [15:0] TONE_MAX = 16'(TONE_HALF - 1);

    logic [15:0] tone_cnt;
    logic        tone_run;

    // The tone follows the red LEDs; a burst continues only while red stays lit
    assign tone_run = (led_r == 2'b00) && red_on_nxt;

    // Tone generator: square wave that always begins each burst low
    always_ff @(posedge clk) begin
        if (!rst) begin
            tone_cnt <= '0;
            beep     <= 1'b0;
        end else if (tone_run) begin
            if (tone_cnt == TONE_MAX) begin
                tone_cnt <= '0;
                beep     <= ~beep;
            end else begin
                tone_cnt <= tone_cnt + 16'd1;
            end
        end else begin
            tone_cnt <= '0;
            beep     <= 1'b0;
        end
    end

`else

    assign beep = 1'b0;

`endif

endmodule

// File: tb/tb_lock_indicator_ctrl.sv
// tb_lock_indicator_ctrl
// Directed vector table for the documented scenarios, then randomized
// stimulus compared each cycle against a behavioural model.
// Beep expectations depend on whether LOCK_INDICATOR_BEEP_EN is defined.

module tb_lock_indicator_ctrl;

    localparam int HOLD  = 10;
    localparam int BLINK = 4;
    localparam int TONE  = 2;

`ifdef LOCK_INDICATOR_BEEP_EN
    localparam bit BEEP_BUILT = 1'b1;
`else
    localparam bit BEEP_BUILT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       pass_pulse;
    logic       fail_pulse;
    logic       lockout;
    logic [1:0] led_r;
    logic [1:0] led_g;
    logic       beep;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        logic       rst_n;
        logic       pass;
        logic       fail;
        logic       lock;
        logic [1:0] r;
        logic [1:0] g;
        logic       bp;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    bit m_locked;
    int m_show;
    int m_remaining;
    int m_lock_age;
    int m_burst;
    bit m_prev_red;

    lock_indicator_ctrl #(
        .HOLD_CYCLES (HOLD),
        .BLINK_CYCLES(BLINK),
        .TONE_HALF   (TONE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pass_pulse(pass_pulse),
        .fail_pulse(fail_pulse),
        .lockout   (lockout),
        .led_r     (led_r),
        .led_g     (led_g),
        .beep      (beep),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void addRow(input logic rst_n, input logic pass, input logic fail,
                                   input logic lock, input logic [1:0] r, input logic [1:0] g,
                                   input logic bp, input logic bsy, input int n);
        vec_t v;
        v.rst_n = rst_n; v.pass = pass; v.fail = fail; v.lock = lock;
        v.r = r; v.g = g; v.bp = bp; v.bsy = bsy;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic rst_n, input logic pass, input logic fail,
                                 input logic lock);
        rst        = rst_n;
        pass_pulse = pass;
        fail_pulse = fail;
        lockout    = lock;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] exp_r,
                               input logic [1:0] exp_g, input logic exp_bp,
                               input logic exp_busy);
        checks++;
        if (led_r !== exp_r) begin
            errors++;
            $display("[TB] FAIL %s led_r cycle %0d: got %b expected %b", name, cycle, led_r, exp_r);
        end
        checks++;
        if (led_g !== exp_g) begin
            errors++;
            $display("[TB] FAIL %s led_g cycle %0d: got %b expected %b", name, cycle, led_g, exp_g);
        end
        checks++;
        if (beep !== exp_bp) begin
            errors++;
            $display("[TB] FAIL %s beep cycle %0d: got %b expected %b", name, cycle, beep, exp_bp);
        end
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("[TB] FAIL %s busy cycle %0d: got %b expected %b", name, cycle, busy, exp_busy);
        end
    endtask

    // Model: what the indicator should show after one clock edge with these inputs
    task automatic modelStep(input logic rst_n, input logic pass, input logic fail,
                             input logic lock, output logic [1:0] r, output logic [1:0] g,
                             output logic bp, output logic bsy);
        bit red_on;
        if (!rst_n) begin
            m_locked = 0; m_show = 0; m_remaining = 0; m_lock_age = 0;
        end else if (m_locked || lock) begin
            m_lock_age = m_locked ? m_lock_age + 1 : 0;
            m_locked   = 1;
            m_show     = 0;
        end else if (fail) begin
            m_show = 2; m_remaining = HOLD;
        end else if (pass) begin
            m_show = 1; m_remaining = HOLD;
        end else if (m_show != 0) begin
            m_remaining--;
            if (m_remaining == 0) m_show = 0;
        end
        red_on     = (m_show == 2) || (m_locked && ((m_lock_age / BLINK) % 2 == 0));
        m_burst    = (red_on && m_prev_red) ? m_burst + 1 : 0;
        m_prev_red = red_on;
        r   = red_on ? 2'b00 : 2'b11;
        g   = (m_show == 1) ? 2'b00 : 2'b11;
        bp  = BEEP_BUILT && red_on && ((m_burst / TONE) % 2 == 1);
        bsy = m_locked || (m_show != 0);
    endtask

    initial begin
        logic [1:0] er;
        logic [1:0] eg;
        logic       eb;
        logic       ebsy;
        logic       r_n;
        logic       p;
        logic       f;
        logic       lk;

        // Reset, then pass at edge 5: green for ten edges
        addRow(0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 3);
        addRow(1, 0, 0, 0, 2'b11, 2'b11, 0, 0, 1);
        addRow(1, 1, 0, 0, 2'b11, 2'b00, 0, 1, 1);
        addRow(1, 0, 0, 0, 2'b11, 2'b00, 0, 1, 9);
        addRow(1, 0, 0, 0, 2'b11, 2'b11, 0, 0, 2);
        // Fail at edge 5, pass retrigger at edge 9
        addRow(0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 3);
        addRow(1, 0, 0, 0, 2'b11, 2'b11, 0, 0, 1);
        addRow(1, 0, 1, 0, 2'b00, 2'b11, 0, 1, 1);
        addRow(1, 0, 0, 0, 2'b00, 2'b11, 0, 1, 1);
        addRow(1, 0, 0, 0, 2'b00, 2'b11, 1, 1, 2);
        addRow(1, 1, 0, 0, 2'b11, 2'b00, 0, 1, 1);
        addRow(1, 0, 0, 0, 2'b11, 2'b00, 0, 1, 9);
        addRow(1, 0, 0, 0, 2'b11, 2'b11, 0, 0, 1);
        // Simultaneous pass and fail: fail wins
        addRow(0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 1);
        addRow(1, 1, 1, 0, 2'b00, 2'b11, 0, 1, 1);
        addRow(1, 0, 0, 0, 2'b00, 2'b11, 0, 1, 1);
        addRow(1, 0, 0, 0, 2'b00, 2'b11, 1, 1, 1);
        // Lockout: blink every BLINK cycles, pass ignored, lockout dropping ignored, reset exits
        addRow(0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 1);
        addRow(1, 0, 0, 1, 2'b00, 2'b11, 0, 1, 2);
        addRow(1, 0, 0, 1, 2'b00, 2'b11, 1, 1, 2);
        addRow(1, 0, 0, 1, 2'b11, 2'b11, 0, 1, 4);
        addRow(1, 0, 0, 1, 2'b00, 2'b11, 0, 1, 2);
        addRow(1, 1, 0, 1, 2'b00, 2'b11, 1, 1, 1);
        addRow(1, 0, 0, 1, 2'b00, 2'b11, 1, 1, 1);
        addRow(1, 0, 1, 0, 2'b11, 2'b11, 0, 1, 2);
        addRow(0, 1, 0, 1, 2'b11, 2'b11, 0, 0, 1);
        addRow(1, 0, 0, 0, 2'b11, 2'b11, 0, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].pass, vecs[i].fail, vecs[i].lock);
            checkOutput("vector", vecs[i].r, vecs[i].g, BEEP_BUILT ? vecs[i].bp : 1'b0, vecs[i].bsy);
        end

        // Randomized run against the model, starting from reset
        m_prev_red = 0;
        m_burst    = 0;
        lk = 1'b0;
        for (int i = 0; i < 800; i++) begin
            r_n = (i < 2) ? 1'b0 : ($urandom_range(0, 59) != 0);
            if (!r_n) lk = 1'b0;
            else if ($urandom_range(0, 79) == 0) lk = 1'b1;
            else if (lk && $urandom_range(0, 19) == 0) lk = 1'b0;
            p = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 11) == 0);
            applyStimulus(r_n, p, f, lk);
            modelStep(r_n, p, f, lk, er, eg, eb, ebsy);
            checkOutput("random", er, eg, eb, ebsy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_indicator_ctrl.md
# lock_indicator_ctrl

Downstream indicator stage for the 24-bit sequence lock. Consumes the single-cycle verdict pulses and the lockout level produced by the code-checking stage. Drives the two red and two green board LEDs (active-low) and an optional piezo tone. Owns all timing of "show pass", "show fail" and "locked" patterns, so the checker never holds LED state itself.

## Interface
- `HOLD_CYCLES`, default 25000000: clk cycles a pass/fail indication stays lit (0.5 s at 50 MHz).
- `BLINK_CYCLES`, default 12500000: half-period of the red blink in lockout.
- `TONE_HALF`, default 25000: half-period of the beep square wave (1 kHz at 50 MHz).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-low reset.
- `pass_pulse`  in  1  one-cycle pulse: entered code matched.
- `fail_pulse`  in  1  one-cycle pulse: entered code mismatched.
- `lockout`  in  1  level: attempt limit reached; sticky until `rst`.
- `led_r`  out  2  red LEDs, active-low; `2'b11` is off.
- `led_g`  out  2  green LEDs, active-low; `2'b11` is off.
- `beep`  out  1  square-wave tone to piezo; 0 when silent.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, PASS_SHOW, FAIL_SHOW, LOCKED.
- Each state drives the outputs as follows:
  - IDLE: `led_r=led_g=2'b11`, `beep=0`.
  - PASS_SHOW: `led_g=2'b00`, `led_r=2'b11`, `beep=0`.
  - FAIL_SHOW: `led_r=2'b00`, `led_g=2'b11`, beep tone active.
  - LOCKED: `led_g=2'b11`. `led_r` toggles between `2'b00` and `2'b11` every `BLINK_CYCLES`, starting at `2'b00` on entry. Beep tone is active while `led_r=2'b00`.
- Transitions are evaluated every cycle. Priority, highest first:
  1. `lockout=1` -> LOCKED, from any state. LOCKED is left only by reset.
  2. `fail_pulse=1` -> FAIL_SHOW. The hold timer restarts, including when already in FAIL_SHOW or PASS_SHOW.
  3. `pass_pulse=1` -> PASS_SHOW. The hold timer restarts.
  4. In PASS_SHOW or FAIL_SHOW, when `hold_cnt == HOLD_CYCLES-1` -> IDLE.
- If `pass_pulse` and `fail_pulse` arrive in the same cycle, fail wins.
- Timers:
  - `hold_cnt` is a 25-bit up-counter. It clears on every state entry and saturates at `HOLD_CYCLES-1`.
  - `blink_cnt` is a 24-bit counter, used only in LOCKED. It wraps at `BLINK_CYCLES-1` and toggles the blink phase on wrap.
  - `tone_cnt` is a 16-bit counter. It wraps at `TONE_HALF-1` and toggles the tone phase. It is held at 0 and tone phase 0 whenever the tone is inactive, so every burst starts low.
- Counter widths must cover the parameter defaults; parameters must be ≥ 2.

## Timing
- All outputs are registered.
- Reset values: `led_r=2'b11`, `led_g=2'b11`, `beep=0`, `busy=0`. State is IDLE and all counters are 0.
- Latency: a pulse sampled at edge N changes the LEDs and `busy` at edge N.
- Pass/fail indication lasts exactly `HOLD_CYCLES` cycles: LEDs are lit after edge N and off after edge N+`HOLD_CYCLES`.
- `lockout` rising, sampled at edge N: red is on after edge N. It first turns off after edge N+`BLINK_CYCLES`.
- First beep high edge is `TONE_HALF` cycles after tone activation.
- Reset mid-indication: outputs return to reset values on the next edge with `rst=0`. Pulses are ignored while `rst=0`.
- `lockout` is a level input and must not be assumed to pulse. Pulses arriving while LOCKED are ignored.

## Configuration
- `LOCK_INDICATOR_BEEP_EN` defined: `tone_cnt` and the tone phase logic are built, and `beep` behaves as above.
- Not defined: the tone logic is absent and `beep` is tied to 0. LED and `busy` behaviour is unchanged.

## Test plan
All scenarios use `HOLD_CYCLES=10`, `BLINK_CYCLES=4`, `TONE_HALF=2`, with the macro defined.
- Reset: hold `rst=0` for 3 cycles -> `led_r=2'b11`, `led_g=2'b11`, `beep=0`, `busy=0`.
- Pass: `pass_pulse` at edge 5 -> `led_g=2'b00` for edges 5..14, `2'b11` after edge 15. `busy` mirrors this; `beep` stays 0.
- Fail retrigger: `fail_pulse` at edge 5, then `pass_pulse` at edge 9 -> red during edges 5..8 with `beep` toggling every 2 cycles (first high after edge 7). Green is on edges 9..18, off after edge 19.
- Simultaneous pulses: `pass_pulse=fail_pulse=1` at edge 3 -> FAIL_SHOW, `led_r=2'b00`, `led_g=2'b11`.
- Lockout: `lockout=1` from edge 20 -> `led_r` is `00`,`11`,`00`… alternating every 4 cycles. `beep` is active only in the `00` phases. A `pass_pulse` at edge 30 has no effect. `rst=0` at edge 40 returns to the reset values.
- Macro undefined: repeat the fail scenario -> `beep` is constantly 0 and the LED waveform is identical.
